// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Captures a 14-bit binary number on request, converts it to four BCD
//   digits with a sequential shift-and-add-3 (double dabble) engine and
//   continuously time-multiplexes the digits onto a shared formatter.
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   value[13:0] : unsigned binary number to display
//   load        : single-cycle capture request (ignored while busy)
//   digit_value : code for the formatter, 0-9 digit, 4'hF blank
//   digit_sel   : active-low one-cold digit enable, bit 0 = least significant
//   busy        : conversion in progress (CONVERT and COMMIT)
//   overflow    : last captured value exceeded 9999
module seven_segment_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  output logic [3:0]  digit_value,
  output logic [3:0]  digit_sel,
  output logic        busy,
  output logic        overflow
);

  localparam int              PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [13:0]     MAX_SHOWN  = 14'd9999;
  localparam logic [3:0]      LAST_ITER  = 4'd13;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t        state_r;
  logic [13:0]   shift_r;
  logic [13:0]   cap_r;
  logic [15:0]   bcd_r;
  logic [3:0]    iter_r;
  logic [15:0]   disp_r;
  logic          busy_r;
  logic          ovf_r;
  logic [PW-1:0] presc_r;
  logic [1:0]    idx_r;
  logic [3:0]    digit_value_r;
  logic [3:0]    digit_sel_r;

  logic [15:0]   bcd_next_s;
  logic          wrap_s;
  logic [1:0]    idx_next_s;
  logic [3:0]    sel_next_s;
  logic [3:0]    shown_s;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in one bit.
  function automatic logic [15:0] dabble_step(input logic [15:0] b, input logic in_bit);
    logic [15:0] a;
    a = b;
    for (int i = 0; i < 4; i++) begin
      a[i*4 +: 4] = (a[i*4 +: 4] >= 4'd5) ? (a[i*4 +: 4] + 4'd3) : a[i*4 +: 4];
    end
    return {a[14:0], in_bit};
  endfunction

  // Code actually shown for one digit: overflow blanks everything, then
  // leading-zero blanking; digit 0 is never treated as a leading zero.
  function automatic logic [3:0] shown_nibble(input logic [15:0] d, input logic ovf,
                                              input logic [1:0] idx, input logic lz);
    logic lead_zero;
    logic [3:0] nib;
    case (idx)
      2'd0:    lead_zero = 1'b0;
      2'd1:    lead_zero = (d[15:4] == 12'd0);
      2'd2:    lead_zero = (d[15:8] == 8'd0);
      2'd3:    lead_zero = (d[15:12] == 4'd0);
      default: lead_zero = 1'b0;
    endcase
    nib = d[{idx, 2'b00} +: 4];
    if (ovf) begin
      return 4'hF;
    end else if (lz && lead_zero) begin
      return 4'hF;
    end else begin
      return nib;
    end
  endfunction

  // Next-state terms for the converter and the scan pipeline.
  always_comb begin
    bcd_next_s = dabble_step(bcd_r, shift_r[13]);
    wrap_s     = (presc_r == PRESC_LAST);
    if (wrap_s) begin
      idx_next_s = idx_r + 2'd1;
    end else begin
      idx_next_s = idx_r;
    end
    sel_next_s = ~(4'b0001 << idx_next_s);
    shown_s    = shown_nibble(disp_r, ovf_r, idx_next_s, LZ_BLANK);
  end

  // Control FSM: capture, 14 shift steps, one commit cycle into the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      shift_r <= 14'd0;
      cap_r   <= 14'd0;
      bcd_r   <= 16'd0;
      iter_r  <= 4'd0;
      disp_r  <= 16'd0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            shift_r <= value;
            cap_r   <= value;
            bcd_r   <= 16'd0;
            iter_r  <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= CONVERT;
          end else begin
            state_r <= IDLE;
          end
        end
        CONVERT: begin
          bcd_r   <= bcd_next_s;
          shift_r <= {shift_r[12:0], 1'b0};
          iter_r  <= iter_r + 4'd1;
          if (iter_r == LAST_ITER) begin
            state_r <= COMMIT;
          end else begin
            state_r <= CONVERT;
          end
        end
        COMMIT: begin
          disp_r  <= bcd_r;
          ovf_r   <= (cap_r > MAX_SHOWN);
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Free-running digit scan; select and code are registered together so
  // they always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r       <= '0;
      idx_r         <= 2'd0;
      digit_sel_r   <= 4'b1110;
      digit_value_r <= 4'h0;
    end else begin
      presc_r       <= wrap_s ? '0 : (presc_r + PRESC_ONE);
      idx_r         <= idx_next_s;
      digit_sel_r   <= sel_next_s;
      digit_value_r <= shown_s;
    end
  end

  assign digit_value = digit_value_r;
  assign digit_sel   = digit_sel_r;
  assign busy        = busy_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed self-checking bench for seven_segment_scanner (SCAN_DIV=4).
// Instance dut uses leading-zero blanking, dut_nolz shows leading zeros;
// both share the same stimulus.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value = 14'd0;
  logic [3:0]  dv_a, ds_a, dv_b, ds_b;
  logic        busy_a, ovf_a, busy_b, ovf_b;
  int          checks = 0;
  int          errors = 0;

  seven_segment_scanner #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .digit_value(dv_a), .digit_sel(ds_a), .busy(busy_a), .overflow(ovf_a));

  seven_segment_scanner #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .digit_value(dv_b), .digit_sel(ds_b), .busy(busy_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Collect the code shown for each digit over a full scan round.
  task automatic read_digits(output logic [15:0] da, output logic [15:0] db);
    da = 16'hEEEE;
    db = 16'hEEEE;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (ds_a == ~(4'b0001 << i)) da[i*4 +: 4] = dv_a;
        if (ds_b == ~(4'b0001 << i)) db[i*4 +: 4] = dv_b;
      end
      @(negedge clk);
    end
  endtask

  // Pulse load and count cycles busy is high; optionally pulse a second load mid-conversion.
  task automatic do_load(input logic [13:0] v, input bit inject, output int cycles);
    value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 40) begin
      cycles++;
      if (inject && cycles == 5) begin
        value = 14'd5678;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ds_a, dv_a, busy_a, ovf_a} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got sel=%b val=%h busy=%b ovf=%b, expected sel=1110 val=0 busy=0 ovf=0",
               ds_a, dv_a, busy_a, ovf_a);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_idle;
    logic [3:0] exp_sel, exp_val;
    int idx;
    for (int n = 0; n < 32; n++) begin
      idx = (n / 4) % 4;
      exp_sel = ~(4'b0001 << idx);
      exp_val = (idx == 0) ? 4'h0 : 4'hF;
      checks++;
      if (ds_a !== exp_sel || dv_a !== exp_val) begin
        errors++;
        $display("FAIL scan_idle[%0d]: got sel=%b val=%h, expected sel=%b val=%h",
                 n, ds_a, dv_a, exp_sel, exp_val);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_convert_1234;
    int cyc;
    logic [15:0] da, db;
    do_load(14'd1234, 1'b1, cyc);
    checks++;
    if (cyc !== 15) begin
      errors++;
      $display("FAIL busy_len_1234: got %0d cycles, expected 15", cyc);
    end
    read_digits(da, db);
    checks++;
    if (da !== 16'h1234) begin
      errors++;
      $display("FAIL digits_1234: got %h, expected 1234", da);
    end
    checks++;
    if (ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL ovf_1234: got %b, expected 0", ovf_a);
    end
  endtask

  task automatic test_overflow;
    int cyc;
    logic [15:0] da, db;
    do_load(14'd9999, 1'b0, cyc);
    read_digits(da, db);
    checks++;
    if (da !== 16'h9999 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL digits_9999: got %h ovf=%b, expected 9999 ovf=0", da, ovf_a);
    end
    do_load(14'd10000, 1'b0, cyc);
    checks++;
    if (cyc !== 15) begin
      errors++;
      $display("FAIL busy_len_10000: got %0d cycles, expected 15", cyc);
    end
    read_digits(da, db);
    checks++;
    if (da !== 16'hFFFF || ovf_a !== 1'b1) begin
      errors++;
      $display("FAIL digits_10000: got %h ovf=%b, expected ffff ovf=1", da, ovf_a);
    end
  endtask

  task automatic test_leading_zero;
    int cyc;
    logic [15:0] da, db;
    do_load(14'd7, 1'b0, cyc);
    read_digits(da, db);
    checks++;
    if (da !== 16'hFFF7 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL digits_7_lz: got %h ovf=%b, expected fff7 ovf=0", da, ovf_a);
    end
    checks++;
    if (db !== 16'h0007 || ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL digits_7_nolz: got %h ovf=%b, expected 0007 ovf=0", db, ovf_b);
    end
    do_load(14'd0, 1'b0, cyc);
    read_digits(da, db);
    checks++;
    if (da !== 16'hFFF0) begin
      errors++;
      $display("FAIL digits_0_lz: got %h, expected fff0", da);
    end
  endtask

  task automatic test_reset_mid_convert;
    logic [15:0] da, db;
    value = 14'd4321;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_abort: got %b, expected 1", busy_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, ds_a, dv_a} !== {1'b0, 4'b1110, 4'h0}) begin
      errors++;
      $display("FAIL async_abort: got busy=%b sel=%b val=%h, expected busy=0 sel=1110 val=0",
               busy_a, ds_a, dv_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    read_digits(da, db);
    checks++;
    if (da !== 16'hFFF0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL digits_after_abort: got %h busy=%b, expected fff0 busy=0", da, busy_a);
    end
  endtask

  task automatic test_load_at_wrap;
    logic [3:0] prev;
    logic [15:0] da, db;
    bit found;
    int run, exp_idx;
    found = 1'b0;
    prev = ds_a;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (ds_a == 4'b0111 && prev != 4'b0111) found = 1'b1;
      prev = ds_a;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wrap_search: digit 3 never entered within 40 cycles");
    end
    repeat (3) @(negedge clk);
    value = 14'd42;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (ds_a !== 4'b1110 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge: got sel=%b busy=%b, expected sel=1110 busy=1", ds_a, busy_a);
    end
    prev = ds_a;
    run = 1;
    exp_idx = 0;
    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      checks++;
      if ($countones(~ds_a) != 1) begin
        errors++;
        $display("FAIL wrap_one_cold[%0d]: got sel=%b, expected exactly one low bit", n, ds_a);
      end
      if (ds_a == prev) begin
        run++;
      end else begin
        checks++;
        if (run != 4 || ds_a !== ~(4'b0001 << ((exp_idx + 1) % 4))) begin
          errors++;
          $display("FAIL wrap_timing[%0d]: got sel=%b after %0d cycles, expected sel=%b after 4",
                   n, ds_a, run, ~(4'b0001 << ((exp_idx + 1) % 4)));
        end
        exp_idx = (exp_idx + 1) % 4;
        run = 1;
      end
      prev = ds_a;
    end
    read_digits(da, db);
    checks++;
    if (da !== 16'hFF42) begin
      errors++;
      $display("FAIL digits_42: got %h, expected ff42", da);
    end
  endtask

  initial begin
    test_reset;
    test_scan_idle;
    test_convert_1234;
    test_overflow;
    test_leading_zero;
    test_reset_mid_convert;
    test_load_at_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
